// File: rtl/joybus_pkg.sv
// Shared JOYBUS device definitions: command codes, info word, FSM states.
// JOYBUS_DEV_INFO_EN enables answering 0x00/0xFF with the info word; otherwise only poll is answered.
package joybus_pkg;

  localparam logic [7:0]  CMD_INFO  = 8'h00;
  localparam logic [7:0]  CMD_POLL  = 8'h01;
  localparam logic [7:0]  CMD_RESET = 8'hFF;
  localparam logic [23:0] INFO_WORD = 24'h050002;

  typedef enum logic [2:0] {
    IDLE, RX_SAMPLE, RX_WAIT, RX_STOP, TURN, TX_BIT, TX_STOP, IGNORE
  } state_t;

  function automatic logic cmd_supported(input logic [7:0] c);
`ifdef JOYBUS_DEV_INFO_EN
    return (c == CMD_POLL) || (c == CMD_INFO) || (c == CMD_RESET);
`else
    return (c == CMD_POLL);
`endif
  endfunction

endpackage

// File: rtl/joybus_dev_tx.sv
// JOYBUS response transmitter: shift register, 4 us bit-cell timer, bit counter.
// Drive output is registered so reset releases the line without a combinational glitch.
module joybus_dev_tx
  import joybus_pkg::*;
#(
  parameter int CYCLES_PER_US = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [5:0]  i_nbits,
  input  logic        i_bit_en,
  input  logic        i_stop_en,
  output logic        o_low,
  output logic        o_bits_done,
  output logic        o_stop_done
);

  localparam logic [15:0] ONE_LOW  = 16'(CYCLES_PER_US);
  localparam logic [15:0] ZERO_LOW = 16'(3 * CYCLES_PER_US);
  localparam logic [15:0] CELL_END = 16'(4 * CYCLES_PER_US - 1);
  localparam logic [15:0] STOP_END = 16'(2 * CYCLES_PER_US - 1);

  logic [31:0] r_shift;
  logic [5:0]  r_left;
  logic [15:0] r_tmr;
  logic        r_low;
  logic        w_cell_end;
  logic        w_low;

  assign w_cell_end  = i_bit_en && (r_tmr == CELL_END);
  assign w_low       = (i_bit_en && (r_tmr < (r_shift[31] ? ONE_LOW : ZERO_LOW))) || i_stop_en;
  assign o_bits_done = w_cell_end && (r_left == 6'd1);
  assign o_stop_done = i_stop_en && (r_tmr == STOP_END);
  assign o_low       = r_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_left  <= '0;
      r_tmr   <= '0;
      r_low   <= 1'b0;
    end else begin
      r_low <= w_low;
      if (i_load) begin
        r_shift <= i_data;
        r_left  <= i_nbits;
        r_tmr   <= '0;
      end else if (w_cell_end) begin
        // cells are back to back: next bit starts on the following cycle
        r_shift <= {r_shift[30:0], 1'b0};
        r_left  <= r_left - 6'd1;
        r_tmr   <= '0;
      end else if (i_bit_en || i_stop_en) begin
        r_tmr <= r_tmr + 16'd1;
      end else begin
        r_tmr <= '0;
      end
    end
  end

endmodule

// File: rtl/joybus_device.sv
// JOYBUS controller-side device: receives a host command byte and answers poll/info.
// Build with JOYBUS_DEV_INFO_EN to also answer 0x00/0xFF with the info word.
module joybus_device
  import joybus_pkg::*;
#(
  parameter int CYCLES_PER_US = 25,
  parameter int TURN_US       = 2,
  parameter int ABORT_US      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jb_in,
  output logic        jb_drive_low,
  input  logic [31:0] btn_state,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic        busy
);

  localparam logic [15:0] SAMPLE_END = 16'(2 * CYCLES_PER_US - 1);
  localparam logic [15:0] ABORT_END  = 16'(ABORT_US * CYCLES_PER_US - 1);
  localparam logic [15:0] TURN_END   = 16'(TURN_US * CYCLES_PER_US - 1);

  logic [1:0]  r_sync;
  logic        r_line_d;
  logic [2:0]  r_own;
  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [7:0]  r_shift;
  logic [3:0]  r_nbits;
  logic        r_cmd_valid;
  logic [7:0]  r_cmd;
  logic        w_line, w_fall, w_rise;
  logic        w_cmd_valid, w_sample;
  logic        w_tx_low, w_tx_bits_done, w_tx_stop_done;
  logic [31:0] w_tx_data;
  logic [5:0]  w_tx_nbits;

  // our own drive reaches the synchronized line up to 3 cycles late; mask edges that long
  assign w_line = r_sync[1];
  assign w_fall = r_line_d && !w_line && !(|r_own) && !w_tx_low;
  assign w_rise = !r_line_d && w_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_line_d <= 1'b1;
      r_own    <= '0;
    end else begin
      r_sync   <= {r_sync[0], jb_in};
      r_line_d <= w_line;
      r_own    <= {r_own[1:0], w_tx_low};
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_valid = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE:      if (w_fall) w_next = RX_SAMPLE;
      RX_SAMPLE: if (r_cnt == SAMPLE_END) begin
                   w_sample = 1'b1;
                   w_next   = RX_WAIT;
                 end
      RX_WAIT:   if (w_fall) w_next = (r_nbits == 4'd8) ? RX_STOP : RX_SAMPLE;
                 else if (r_cnt == ABORT_END) w_next = IDLE;
      RX_STOP:   if (w_rise) begin
                   w_cmd_valid = 1'b1;
                   w_next      = cmd_supported(r_shift) ? TURN : IGNORE;
                 end
      TURN:      if (r_cnt == TURN_END) w_next = TX_BIT;
      TX_BIT:    if (w_tx_bits_done) w_next = TX_STOP;
      TX_STOP:   if (w_tx_stop_done) w_next = IDLE;
      IGNORE:    if (r_cnt == ABORT_END) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_nbits     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
    end else begin
      r_state     <= w_next;
      r_cmd_valid <= w_cmd_valid;
      if (w_cmd_valid) r_cmd <= r_shift;
      // in the high-timeout states the counter measures continuous line-high time
      if ((w_next != r_state) || (r_state == IDLE))
        r_cnt <= '0;
      else if (((r_state == RX_WAIT) || (r_state == IGNORE)) && !w_line)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 16'd1;
      if (r_state == IDLE) begin
        r_nbits <= '0;
      end else if (w_sample) begin
        r_shift <= {r_shift[6:0], w_line};
        r_nbits <= r_nbits + 4'd1;
      end
    end
  end

  assign w_tx_data  = (r_cmd == CMD_POLL) ? btn_state : {INFO_WORD, 8'h00};
  assign w_tx_nbits = (r_cmd == CMD_POLL) ? 6'd32 : 6'd24;

  joybus_dev_tx #(.CYCLES_PER_US(CYCLES_PER_US)) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_cmd_valid),
    .i_data     (w_tx_data),
    .i_nbits    (w_tx_nbits),
    .i_bit_en   (r_state == TX_BIT),
    .i_stop_en  (r_state == TX_STOP),
    .o_low      (w_tx_low),
    .o_bits_done(w_tx_bits_done),
    .o_stop_done(w_tx_stop_done)
  );

  assign jb_drive_low = w_tx_low;
  assign cmd_valid    = r_cmd_valid;
  assign cmd          = r_cmd;
  assign busy         = (r_state != IDLE);

endmodule

// File: doc/joybus_device.md
JOYBUS_DEVICE -- requirements
Module: joybus_device

Interface
REQ-001 SHALL have parameter CYCLES_PER_US, default 25, meaning clk cycles per microsecond (25 MHz clk).
REQ-002 SHALL have parameter TURN_US, default 2, meaning idle gap in us between host stop bit and device response.
REQ-003 SHALL have parameter ABORT_US, default 8, meaning max line-high time in us inside a command before abort.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 jb_in  input  1  raw JOYBUS line level (asynchronous; pulled up when no one drives).
REQ-007 jb_drive_low  output  1  1 = pull line low (open-drain enable at top level); 0 = release.
REQ-008 btn_state  input  32  controller state, bit 31 first (A,B,Z,Start in 31..28).
REQ-009 cmd_valid  output  1  one-cycle pulse when a complete command byte plus stop bit is received.
REQ-010 cmd  output  8  last received command byte, held until next cmd_valid.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 jb_in SHALL pass a 2-FF synchronizer; all decoding uses the synchronized level.
REQ-013 Bit cell SHALL be 4 us: '0' = 3 us low + 1 us high; '1' = 1 us low + 3 us high; host stop = 1 us low; device stop = 2 us low.
REQ-014 FSM states SHALL be IDLE, RX_SAMPLE, RX_WAIT, RX_STOP, TURN, TX_BIT, TX_STOP, IGNORE.
REQ-015 IDLE -> RX_SAMPLE on synchronized falling edge; bit counter cleared.
REQ-016 RX_SAMPLE SHALL sample line 2*CYCLES_PER_US cycles after the falling edge: low = 0, high = 1, shifted MSB first; then RX_WAIT.
REQ-017 RX_WAIT: next falling edge -> RX_SAMPLE if fewer than 8 bits taken, else RX_STOP; line high for ABORT_US -> IDLE, no cmd_valid.
REQ-018 RX_STOP: on rising edge, pulse cmd_valid, update cmd; supported command -> TURN, otherwise -> IGNORE.
REQ-019 Supported commands: 0x01 (poll) responds with 32 bits of btn_state; 0x00 and 0xFF (info/reset) respond with 24 bits 0x050002.
REQ-020 btn_state SHALL be latched into the TX shift register on the cmd_valid cycle; later changes do not affect the response.
REQ-021 TURN SHALL hold line released for TURN_US*CYCLES_PER_US cycles, then -> TX_BIT.
REQ-022 TX_BIT SHALL drive each bit per REQ-013, MSB first, with no gap between cells; after last bit -> TX_STOP.
REQ-023 TX_STOP SHALL drive low 2*CYCLES_PER_US cycles, release, -> IDLE.
REQ-024 IGNORE SHALL never drive; -> IDLE after line stays high ABORT_US.
REQ-025 jb_drive_low SHALL be 0 in all states except low phases of TX_BIT/TX_STOP.
REQ-026 Falling edges seen on jb_in while the device itself drives SHALL be ignored.

Reset
REQ-027 On rst_n low, immediately: state IDLE, jb_drive_low 0, cmd_valid 0, cmd 0x00, busy 0, counters and shift registers 0.
REQ-028 Reset asserted mid-transmission SHALL release the line within the same cycle (asynchronous path, no glitch).

Configuration
REQ-029 Macro JOYBUS_DEV_INFO_EN: defined -> 0x00/0xFF answered per REQ-019; undefined -> 0x00/0xFF treated as unsupported (IGNORE), only 0x01 answered.

Structure
REQ-030 Package joybus_pkg SHALL hold command codes (CMD_INFO, CMD_POLL, CMD_RESET), info word 0x050002, and the FSM state enum.
REQ-031 Sub-module joybus_dev_tx SHALL contain the TX shift register, bit-cell timer and bit counter; joybus_device holds RX and the FSM.

Verification
REQ-032 Host sends 0x01 + stop, btn_state=0x8000_0000 -> cmd_valid with cmd=0x01; 2 us later: one '1' cell, 31 '0' cells, 2 us stop; busy falls.
REQ-033 Host sends 0x00 (macro defined) -> 24-bit 0x050002 response; macro undefined -> no drive, IDLE 8 us after stop.
REQ-034 Host sends 0x02 -> cmd_valid with cmd=0x02, jb_drive_low stays 0, returns to IDLE.
REQ-035 Host stops after 5 bits -> IDLE after 8 us high, no cmd_valid, no drive.
REQ-036 Poll with btn_state=0xF000_0000, changed to 0 during TURN -> response bits 31..28 still 1.
REQ-037 rst_n pulsed low during bit 10 of a response -> jb_drive_low 0 that cycle; next 0x01 poll answered normally.
